// File: rtl/divider_pkg.sv
// Shared encodings for the restoring divider controller and datapath.
package divider_pkg;

  localparam int unsigned DIV_WIDTH_DEFAULT = 8;

  // A-register source select driven by the controller
  typedef enum logic [1:0] {
    SEL_HOLD = 2'b00,
    SEL_ALU  = 2'b01,
    SEL_LOAD = 2'b10,
    SEL_PASS = 2'b11
  } sel_t;

endpackage

// File: rtl/divider_addsub.sv
// Combinational WIDTH+1-bit add/subtract used for the A register update and the trial sign.
module divider_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0] i_a,
  input  logic [WIDTH:0] i_m,
  input  logic           i_add,
  output logic [WIDTH:0] o_res
);

  assign o_res = i_add ? (i_a + i_m) : (i_a - i_m);

endmodule

// File: rtl/divider_datapath.sv
// Restoring unsigned divider datapath (A/Q/M registers, iteration counter, done flag).
// Optional DIVIDER_DIVZERO_EN adds a div_by_zero flag and a one-cycle divide-by-zero result.
module divider_datapath
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             add,
  input  logic             shift,
  input  logic             inbit,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             sign,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
`ifdef DIVIDER_DIVZERO_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [AW-1:0]    r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  logic [AW-1:0]    w_m_ext;
  logic [AW-1:0]    w_alu;
  logic [AW-1:0]    w_diff;
  logic [AW-1:0]    w_src;
  logic             w_last;
  logic             w_dz_fire;

  assign w_m_ext = {1'b0, r_m};

  divider_addsub #(.WIDTH(WIDTH)) u_alu (
    .i_a   (r_a),
    .i_m   (w_m_ext),
    .i_add (add),
    .o_res (w_alu)
  );

  // Trial subtract is always A-M so the controller can branch in the SUB cycle
  divider_addsub #(.WIDTH(WIDTH)) u_trial (
    .i_a   (r_a),
    .i_m   (w_m_ext),
    .i_add (1'b0),
    .o_res (w_diff)
  );

  always_comb begin
    w_src = r_a;
    if (sel_t'(sel) == SEL_ALU) w_src = w_alu;
  end

  assign w_last = (r_cnt == CW'(WIDTH - 1));

`ifdef DIVIDER_DIVZERO_EN
  logic r_dz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_dz <= 1'b0;
    else if (load) r_dz <= (divisor == '0);
  end

  assign w_dz_fire   = r_dz & ~r_done & ~load;
  assign div_by_zero = r_dz;
`else
  assign w_dz_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a    <= '0;
      r_q    <= '0;
      r_m    <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (load) begin
      // First left shift of {A,Q} is folded into the load
      r_a    <= {{WIDTH{1'b0}}, dividend[WIDTH-1]};
      r_q    <= {dividend[WIDTH-2:0], 1'b0};
      r_m    <= divisor;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (!r_done) begin
      if (w_dz_fire) begin
        // Dividend is still recoverable from the load-time {A[0], Q[W-1:1]}
        r_a    <= {1'b0, r_a[0], r_q[WIDTH-1:1]};
        r_q    <= '1;
        r_cnt  <= CW'(WIDTH);
        r_done <= 1'b1;
      end else if (!shift) begin
        r_a <= w_src;
      end else if (!w_last) begin
        r_a   <= {w_src[WIDTH-1:0], r_q[WIDTH-1]};
        r_q   <= {r_q[WIDTH-2:0], inbit};
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_a    <= w_src;
        r_q    <= {r_q[WIDTH-2:0], inbit};
        r_cnt  <= CW'(WIDTH);
        r_done <= 1'b1;
      end
    end
  end

  assign sign      = w_diff[AW-1];
  assign quotient  = r_q;
  assign remainder = r_a[WIDTH-1:0];
  assign done      = r_done;

endmodule

// File: tb/tb_divider_datapath.sv
// Directed bench for divider_datapath; the bench plays the controller and checks hand-computed results.
module tb_divider_datapath;
  import divider_pkg::*;

  localparam int unsigned W = 8;

  logic         clk      = 1'b0;
  logic         reset    = 1'b1;
  logic         load     = 1'b0;
  logic         add      = 1'b0;
  logic         shift    = 1'b0;
  logic         inbit    = 1'b0;
  logic [1:0]   sel      = 2'b00;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor  = '0;
  logic         sign;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         done;
`ifdef DIVIDER_DIVZERO_EN
  logic         div_by_zero;
`endif

  int checks = 0;
  int errors = 0;

  divider_datapath #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .add       (add),
    .shift     (shift),
    .inbit     (inbit),
    .sel       (sel),
    .dividend  (dividend),
    .divisor   (divisor),
    .sign      (sign),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done)
`ifdef DIVIDER_DIVZERO_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    load     = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    step();
    load = 1'b0;
  endtask

  // Acts as the controller: SUB, then RESTORE or ACCEPT depending on sign
  task automatic run_div(input string tag, input logic [W-1:0] exp_sign, input int ncyc);
    logic [W-1:0] obs_sign;
    logic         s;
    obs_sign = '0;
    s        = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      load = 1'b0;
      if (c % 2 == 0) begin
        sel = SEL_ALU; add = 1'b0; shift = 1'b0; inbit = 1'b0;
        s = sign;
        obs_sign = {obs_sign[W-2:0], s};
      end else if (s) begin
        sel = SEL_ALU; add = 1'b1; shift = 1'b1; inbit = 1'b0;
      end else begin
        sel = SEL_PASS; add = 1'b0; shift = 1'b1; inbit = 1'b1;
      end
      step();
      if (ncyc == 2 * W && c == 2 * W - 2) check({tag, "_done_early"}, 32'(done), 0);
    end
    sel = SEL_HOLD; add = 1'b0; shift = 1'b0; inbit = 1'b0;
    if (ncyc == 2 * W) begin
      check({tag, "_sign_pattern"}, 32'(obs_sign), 32'(exp_sign));
      check({tag, "_done"}, 32'(done), 1);
    end
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_q", 32'(quotient), 0);
    check("rst_r", 32'(remainder), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sign", 32'(sign), 0);
    @(negedge clk);
    reset = 1'b0;

    // 100 / 7 = 14 r 2
    do_load(8'd100, 8'd7);
    run_div("d100_7", 8'b1111_0001, 16);
    check("d100_7_q", 32'(quotient), 14);
    check("d100_7_r", 32'(remainder), 2);

    // Strobes after done are ignored
    for (int i = 0; i < 10; i++) begin
      sel   = 2'($urandom_range(0, 3));
      add   = 1'($urandom_range(0, 1));
      shift = 1'($urandom_range(0, 1));
      inbit = 1'($urandom_range(0, 1));
      step();
      check("hold_q", 32'(quotient), 14);
      check("hold_r", 32'(remainder), 2);
      check("hold_done", 32'(done), 1);
    end
    sel = SEL_HOLD; add = 1'b0; shift = 1'b0; inbit = 1'b0;

    // 255 / 1; load clears done
    do_load(8'd255, 8'd1);
    check("load_clears_done", 32'(done), 0);
    run_div("d255_1", 8'b0000_0000, 16);
    check("d255_1_q", 32'(quotient), 255);
    check("d255_1_r", 32'(remainder), 0);

    // 5 / 9: divisor larger than dividend
    do_load(8'd5, 8'd9);
    run_div("d5_9", 8'b1111_1111, 16);
    check("d5_9_q", 32'(quotient), 0);
    check("d5_9_r", 32'(remainder), 5);

    // 200 / 0
    do_load(8'd200, 8'd0);
`ifdef DIVIDER_DIVZERO_EN
    check("dz_flag", 32'(div_by_zero), 1);
    check("dz_done_at_load", 32'(done), 0);
    step();
    check("dz_done", 32'(done), 1);
    check("dz_q", 32'(quotient), 255);
    check("dz_r", 32'(remainder), 200);
`else
    run_div("d200_0", 8'b0000_0000, 16);
    check("d200_0_q", 32'(quotient), 255);
    check("d200_0_r", 32'(remainder), 200);
`endif

    // Asynchronous reset in cycle 7 of a division
    do_load(8'd100, 8'd7);
`ifdef DIVIDER_DIVZERO_EN
    check("dz_flag_cleared", 32'(div_by_zero), 0);
`endif
    run_div("d100_7_part", 8'b0, 7);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_q", 32'(quotient), 0);
    check("mid_rst_r", 32'(remainder), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_sign", 32'(sign), 0);
    step();
    reset = 1'b0;

    // 13 / 3 = 4 r 1 after reset
    do_load(8'd13, 8'd3);
    run_div("d13_3", 8'b1111_1011, 16);
    check("d13_3_q", 32'(quotient), 4);
    check("d13_3_r", 32'(remainder), 1);

    // Held load with changing operands and active strobes; last is 60 / 4
    load = 1'b1; sel = SEL_ALU; shift = 1'b1; inbit = 1'b1;
    dividend = 8'd10; divisor = 8'd3; step();
    dividend = 8'd99; divisor = 8'd7; step();
    dividend = 8'd60; divisor = 8'd4; step();
    load = 1'b0;
    check("hold_load_done", 32'(done), 0);
    run_div("d60_4", 8'b1111_0000, 16);
    check("d60_4_q", 32'(quotient), 15);
    check("d60_4_r", 32'(remainder), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
